// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single carry flop.
// FSM: S_IDLE waits for start | S_SHIFT adds one bit per edge | S_DONE pulses done for one cycle.

module serial_adder_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, ovf_q, busy_q, done_q;
    logic             ha0_s, ha0_c, ha1_s, ha1_c;

    serial_adder_ha u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .s_o(ha0_s), .c_o(ha0_c));
    serial_adder_ha u_ha1 (.a_i(ha0_s),  .b_i(carry_q), .s_o(ha1_s), .c_o(ha1_c));

    assign carry_d = ha0_c | ha1_c;
    assign sum_d   = {ha1_s, sum_q[WIDTH-1:1]};
    assign cnt_d   = cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    if (cnt_q == LAST) begin
                        // carry_q here is the carry into the MSB
                        ovf_q   <= carry_q ^ carry_d;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;
endmodule
